// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU load/store port and the
// loader/debug port, stalling the CPU while it waits for the memory.
module dmem_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              CNT_W      = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CPU_RD = 2'd1;
    localparam logic [1:0] LD_RD  = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              arb_ok, cpu_win, ld_win;
    logic [ADDR_W-1:0] cpu_word;
    logic              unused_addr_bits;

    // Byte address to word index; upper bits wrap by being dropped.
    assign cpu_word         = cpu_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        state_nxt  = IDLE;

        // Arbitration only happens in IDLE and is suppressed while reset is held.
        arb_ok  = rst && (state == IDLE);
        ld_win  = arb_ok && ld_req && ((wait_cnt == WAIT_LIMIT) || !cpu_req);
        cpu_win = arb_ok && cpu_req && !ld_win;

        if (cpu_win) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_word;
            mem_wdata = cpu_wdata;
        end else if (ld_win) begin
            mem_en    = 1'b1;
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end

        if (cpu_win && !cpu_we) begin
            state_nxt = CPU_RD;
        end else if (ld_win && !ld_we) begin
            state_nxt = LD_RD;
        end

        ld_gnt     = ld_win;
        cpu_rvalid = rst && (state == CPU_RD);
        ld_rvalid  = rst && (state == LD_RD);
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        ld_rdata   = ld_rvalid  ? mem_rdata : '0;
        cpu_stall  = cpu_req && !cpu_rvalid && !(cpu_win && cpu_we);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (ld_req && !ld_win) begin
                wait_cnt <= (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer for the single-port data memory. It shares the memory between the CPU load/store port and a loader/debug port (program/data download, memory inspection), and stalls the CPU whenever it loses arbitration or waits for read data. It sits between the MemOrIO address/data path and Data_mem, on the divided CPU clock.

## Interface
- ADDR_W, 14, memory word-address width (16K words)
- DATA_W, 32, data width
- MAX_WAIT, 4, cycles the loader may be refused before it is forced ahead of the CPU (1..15)

- clk  in  1  CPU clock (divided clock domain)
- rst  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU memory access request, held until completion
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  byte address; word index = cpu_addr[ADDR_W+1:2], bits [1:0] ignored
- cpu_wdata  in  DATA_W  write data
- cpu_stall  out  1  hold PC and instruction this cycle
- cpu_rdata  out  DATA_W  read data, valid with cpu_rvalid
- cpu_rvalid  out  1  CPU read data returned this cycle
- ld_req, ld_we  in  1  loader request, 1 = write
- ld_addr  in  ADDR_W  loader word address
- ld_wdata  in  DATA_W  loader write data
- ld_gnt  out  1  loader access accepted this cycle
- ld_rdata  out  DATA_W  loader read data
- ld_rvalid  out  1  loader read data returned this cycle
- mem_en, mem_we  out  1  memory enable / write enable
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, registered, 1-cycle latency

## Operation
- States: IDLE, CPU_RD, LD_RD. Grants are issued only in IDLE; at most one grant per cycle.
- IDLE arbitration: if wait_cnt == MAX_WAIT and ld_req -> loader; else if cpu_req -> CPU; else if ld_req -> loader; else no access.
- Grant drives mem_en=1, mem_we=requester's we, mem_addr/mem_wdata from winner. No grant: mem_en=0, mem_we=0, mem_addr/mem_wdata = 0.
- Granted write: completes in grant cycle, state stays IDLE.
- Granted read: next state CPU_RD or LD_RD. In that state mem_rdata routes to the owner's rdata with its rvalid=1; return to IDLE next cycle. No grant issued in CPU_RD/LD_RD.
- cpu_stall = cpu_req & ~(state==CPU_RD) & ~(CPU write granted this cycle). CPU read: stalled in grant cycle, released in CPU_RD cycle.
- ld_gnt = 1 only in loader grant cycle (read or write).
- wait_cnt ($clog2(MAX_WAIT+1) bits): +1, saturating at MAX_WAIT, each cycle ld_req=1 and ld_gnt=0; cleared on ld_gnt or ld_req=0.
- cpu_rdata/ld_rdata: pass mem_rdata only when the matching rvalid is 1, else 0.

## Timing
- Reset (rst=0 at clk edge): state IDLE, wait_cnt 0; in-flight read discarded. Combinational outputs then read as IDLE-state values: no rvalid, ld_gnt=0, cpu_stall=cpu_req & ~cpu_we... i.e., per IDLE rules with arbitration suppressed: mem_en=0, ld_gnt=0, cpu_stall=cpu_req, all rdata/rvalid 0 while rst=0.
- CPU write latency: 0 extra cycles when uncontended. CPU read: 1 stall cycle, data in following cycle.
- Loader read: ld_gnt in cycle N, ld_rvalid/ld_rdata in N+1.
- Simultaneous cpu_req and ld_req in IDLE with wait_cnt < MAX_WAIT: CPU wins.
- Starvation bound: a loader request is granted within MAX_WAIT+2 cycles regardless of CPU traffic.
- Requests arriving during CPU_RD/LD_RD wait one cycle; counter still increments for the loader.
- Request dropped after grant (read): data still returned in RD state; rvalid asserted regardless.
- Addresses beyond ADDR_W bits: upper CPU address bits ignored (wrap).

## Test plan
- Reset: rst=0 for 2 cycles with cpu_req=1 -> mem_en=0, cpu_stall=1, rvalids 0; after release, state IDLE, grant on first cycle.
- CPU write 0xDEADBEEF to 0x0000_0010 then read -> write: mem_addr=4, mem_we=1, cpu_stall=0; read: stall 1 cycle, next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF.
- Loader-only write 0x12345678 to word 7, then read word 7 -> ld_gnt each issue cycle, ld_rvalid next cycle with 0x12345678.
- Contention: cpu_req held continuously (reads), ld_req from cycle 0, MAX_WAIT=4 -> loader granted once wait_cnt reaches 4, CPU stalled that cycle, counter cleared.
- Simultaneous req, wait_cnt=0 -> CPU granted, ld_gnt=0, wait_cnt=1.
- rst=0 during CPU_RD -> next cycle cpu_rvalid=0, state IDLE, no stale data delivered.
